vproc_cache_arbiter: RTL and testbench
======================================

# vproc_cache_arbiter

Two-requester arbiter in front of the vector-unit data cache: shares the single CPU-side request port of the cache between requester 0 (scalar core data port) and requester 1 (vector load/store unit). Arbitrates per request, forwards the winner combinationally to the cache and routes each cache response back to its originator using an in-order ID FIFO. Sits between the requesters and the cache; the cache's memory side is untouched.

## Interface
- ADDR_BIT_W, 32, address width (bits)
- BYTE_W, 4, data width (bytes), equal to cache CPU_BYTE_W
- MAX_OUTSTANDING, 2, max granted-but-unanswered requests (power of 2, ≥1)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  2  request per requester (bit n = requester n)
- addr_i  in  2*ADDR_BIT_W  address, requester n at [n*ADDR_BIT_W +: ADDR_BIT_W]
- we_i  in  2  write enable
- be_i  in  2*BYTE_W  byte enables
- wdata_i  in  2*BYTE_W*8  write data
- gnt_o  out  2  grant, one-hot or zero
- rvalid_o  out  2  response valid, one-hot or zero
- rdata_o  out  BYTE_W*8  read data, shared by both requesters
- err_o  out  1  response error, shared
- cache_req_o  out  1  request to cache
- cache_addr_o  out  ADDR_BIT_W  forwarded address
- cache_we_o  out  1  forwarded write enable
- cache_be_o  out  BYTE_W  forwarded byte enables
- cache_wdata_o  out  BYTE_W*8  forwarded write data
- cache_gnt_i  in  1  cache grant
- cache_rvalid_i  in  1  cache response valid (one per granted request, reads and writes)
- cache_rdata_i  in  BYTE_W*8  cache read data
- cache_err_i  in  1  cache error

## Operation
- Requesters hold req/addr/we/be/wdata stable until gnt; arbiter never registers request payload.
- `full` = outstanding count == MAX_OUTSTANDING. When full: cache_req_o=0, gnt_o=0, even if cache_rvalid_i=1 that cycle.
- Winner `sel` chosen combinationally from req_i and priority state; cache_req_o = |req_i & ~full; cache_* payload muxed from `sel` (requester 0 payload when no request).
- gnt_o[sel] = cache_req_o & cache_gnt_i; the losing requester sees gnt 0 and keeps requesting.
- On grant: push `sel` into ID FIFO (depth MAX_OUTSTANDING), count +1.
- On cache_rvalid_i: pop FIFO head h, rvalid_o[h]=1, count −1. rdata_o/err_o pass through combinationally from cache.
- Grant and response in same cycle: push and pop both occur, count unchanged.
- cache_rvalid_i with empty FIFO: dropped (rvalid_o=0), count stays 0; simulation assertion fires.
- Responses return strictly in grant order; the cache answers in order.

## Timing
- Request path fully combinational: req_i→cache_req_o, cache_gnt_i→gnt_o, zero added latency.
- Response path combinational: cache_rvalid_i→rvalid_o same cycle, using registered FIFO head.
- Registered state: FIFO entries, read/write pointers (wrap modulo MAX_OUTSTANDING), count (width $clog2(MAX_OUTSTANDING)+1), priority pointer.
- Reset: count 0, pointers 0, priority pointer 0 (requester 0 preferred). With req_i=0 and cache_rvalid_i=0 all outputs 0; rvalid_o is 0 throughout reset.
- Reset mid-operation discards all outstanding IDs; the cache must be reset concurrently.

## Configuration
- VPROC_CACHE_ARB_RR_EN defined: round-robin. On each grant, priority pointer moves to the other requester; with both requesting, sel = preferred requester. Pointer unchanged when no grant.
- Undefined: fixed priority, requester 0 always wins; priority pointer removed.

## Test plan
- Single read: req_i=01, addr 0x2000, cache grants cycle 0, rvalid cycle 3 with rdata 0xDEADBEEF -> gnt_o=01 cycle 0, rvalid_o=01 cycle 3, rdata_o=0xDEADBEEF.
- Contention: req_i=11 held, cache_gnt_i=1 always -> RR: grants alternate 01,10,01,10 from reset; fixed: 01 every cycle, requester 1 starved.
- Interleaved responses: grant r0 then r1 back-to-back, two rvalids -> rvalid_o=01 then 10 in that order.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid -> third cycle cache_req_o=0, gnt_o=00; after one rvalid, next cycle grant resumes.
- Simultaneous grant+rvalid at count 1 -> count stays 1, correct head ID returned, new ID queued.
- Spurious cache_rvalid_i at count 0 -> rvalid_o=00, assertion fires, count 0; async reset mid-burst -> count 0, next response dropped.

Source files
------------

// File: rtl/vproc_cache_arbiter.sv
// Two-requester arbiter sharing the vector data cache CPU port; routes responses via an in-order ID FIFO.
// Latency: zero-cycle request path (req/gnt combinational) and zero-cycle response path (rvalid combinational).
// Backpressure: losing or stalled requester holds its request; no request is forwarded while MAX_OUTSTANDING are unanswered.
// Optional: define VPROC_CACHE_ARB_RR_EN for round-robin priority, otherwise requester 0 has fixed priority.
module vproc_cache_arbiter #(
  parameter int unsigned ADDR_BIT_W      = 32,
  parameter int unsigned BYTE_W          = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                req_i,
  input  logic [2*ADDR_BIT_W-1:0]   addr_i,
  input  logic [1:0]                we_i,
  input  logic [2*BYTE_W-1:0]       be_i,
  input  logic [2*BYTE_W*8-1:0]     wdata_i,
  output logic [1:0]                gnt_o,
  output logic [1:0]                rvalid_o,
  output logic [BYTE_W*8-1:0]       rdata_o,
  output logic                      err_o,
  output logic                      cache_req_o,
  output logic [ADDR_BIT_W-1:0]     cache_addr_o,
  output logic                      cache_we_o,
  output logic [BYTE_W-1:0]         cache_be_o,
  output logic [BYTE_W*8-1:0]       cache_wdata_o,
  input  logic                      cache_gnt_i,
  input  logic                      cache_rvalid_i,
  input  logic [BYTE_W*8-1:0]       cache_rdata_i,
  input  logic                      cache_err_i
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned DATA_W = BYTE_W * 8;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             id_q [MAX_OUTSTANDING];
  logic             id_d [MAX_OUTSTANDING];

  logic sel;
  logic full;
  logic push;
  logic pop;
  logic head_id;

`ifdef VPROC_CACHE_ARB_RR_EN
  logic prio_q, prio_d;
`endif

  // Pointers wrap modulo the FIFO depth, which need not fill the pointer width.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Winner selection: a lone requester always wins; on contention the priority state decides.
  always_comb begin
`ifdef VPROC_CACHE_ARB_RR_EN
    if (req_i == 2'b11) begin
      sel = prio_q;
    end else begin
      sel = req_i[1] & ~req_i[0];
    end
`else
    sel = req_i[1] & ~req_i[0];
`endif
  end

  assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign push    = cache_req_o & cache_gnt_i;
  // A response with nothing outstanding has no owner, so it is dropped rather than popped.
  assign pop     = cache_rvalid_i & (count_q != '0);
  assign head_id = id_q[rptr_q];

  // Forward the winner's payload to the cache and route grant/response strobes back.
  always_comb begin
    cache_req_o   = (|req_i) & ~full;
    cache_addr_o  = sel ? addr_i[2*ADDR_BIT_W-1:ADDR_BIT_W] : addr_i[ADDR_BIT_W-1:0];
    cache_we_o    = sel ? we_i[1] : we_i[0];
    cache_be_o    = sel ? be_i[2*BYTE_W-1:BYTE_W] : be_i[BYTE_W-1:0];
    cache_wdata_o = sel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
    gnt_o         = push ? (sel ? 2'b10 : 2'b01) : 2'b00;
    rvalid_o      = pop ? {head_id, ~head_id} : 2'b00;
    rdata_o       = cache_rdata_i;
    err_o         = cache_err_i;
  end

  // Next-state for the ID FIFO, occupancy count and priority pointer.
  always_comb begin
    id_d   = id_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    if (push) begin
      id_d[wptr_q] = sel;
      wptr_d       = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
`ifdef VPROC_CACHE_ARB_RR_EN
    prio_d = prio_q;
    if (push) begin
      prio_d = ~sel;
    end
`endif
  end

  // State registers; reset discards every outstanding ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_q[i] <= 1'b0;
      end
`ifdef VPROC_CACHE_ARB_RR_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      id_q    <= id_d;
`ifdef VPROC_CACHE_ARB_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end

  // Report cache responses that arrive with no request outstanding (they are dropped).
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(cache_rvalid_i && (count_q == '0)))
        else $warning("vproc_cache_arbiter: cache response with no outstanding request dropped");
    end
  end

endmodule

// File: tb/tb_vproc_cache_arbiter.sv
// Randomized and directed bench for vproc_cache_arbiter against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after the edge.
// Model: outstanding IDs kept in a queue; priority follows the round-robin / fixed rules of the selected build.
module tb_vproc_cache_arbiter;

  localparam int AW   = 32;
  localparam int BW   = 4;
  localparam int DW   = BW * 8;
  localparam int MAXO = 2;

`ifdef VPROC_CACHE_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic          cgnt = 1'b0;
  logic          crv = 1'b0;
  logic [DW-1:0] rdat = '0;
  logic          cerr = 1'b0;

  logic [AW-1:0] a_addr [2];
  logic          a_we   [2];
  logic [BW-1:0] a_be   [2];
  logic [DW-1:0] a_wd   [2];

  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o, cache_wdata_o;
  logic          err_o, cache_req_o, cache_we_o;
  logic [AW-1:0] cache_addr_o;
  logic [BW-1:0] cache_be_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int q[$];
  int m_prio = 0;

  // Model expectations for the current input set
  int            e_sel;
  logic [1:0]    e_gnt, e_rv;
  logic          e_creq;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wd;

  vproc_cache_arbiter #(.ADDR_BIT_W(AW), .BYTE_W(BW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .addr_i        ({a_addr[1], a_addr[0]}),
    .we_i          ({a_we[1], a_we[0]}),
    .be_i          ({a_be[1], a_be[0]}),
    .wdata_i       ({a_wd[1], a_wd[0]}),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .cache_req_o   (cache_req_o),
    .cache_addr_o  (cache_addr_o),
    .cache_we_o    (cache_we_o),
    .cache_be_o    (cache_be_o),
    .cache_wdata_o (cache_wdata_o),
    .cache_gnt_i   (cgnt),
    .cache_rvalid_i(crv),
    .cache_rdata_i (rdat),
    .cache_err_i   (cerr)
  );

  always #5 clk = ~clk;

  function automatic void model_expect();
    if (req == 2'b11) e_sel = RR_MODE ? m_prio : 0;
    else if (req == 2'b10) e_sel = 1;
    else e_sel = 0;
    e_creq = (req != 2'b00) && (q.size() < MAXO);
    e_gnt  = (e_creq && cgnt) ? (e_sel == 1 ? 2'b10 : 2'b01) : 2'b00;
    e_rv   = (crv && q.size() > 0) ? (q[0] == 1 ? 2'b10 : 2'b01) : 2'b00;
    e_addr = a_addr[e_sel];
    e_we   = a_we[e_sel];
    e_be   = a_be[e_sel];
    e_wd   = a_wd[e_sel];
  endfunction

  function automatic void model_update();
    model_expect();
    if (e_rv != 2'b00) void'(q.pop_front());
    if (e_gnt != 2'b00) begin
      q.push_back(e_sel);
      if (RR_MODE) m_prio = 1 - e_sel;
    end
  endfunction

  task automatic drive(input logic [1:0] r, input logic g, input logic v);
    req = r; cgnt = g; crv = v;
    #2;
    model_expect();
  endtask

  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00; cgnt = 1'b0; crv = 1'b0;
    q.delete();
    m_prio = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      a_addr[n] = '0; a_we[n] = 1'b0; a_be[n] = '0; a_wd[n] = '0;
    end
    rst_n = 1'b0; req = 2'b00; cgnt = 1'b0; crv = 1'b0; rdat = '0; cerr = 1'b0;
    #3;
    n_cmp++;
    if ({gnt_o, rvalid_o, rdata_o, err_o, cache_req_o, cache_addr_o, cache_we_o, cache_be_o, cache_wdata_o} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: outputs gnt=%b rv=%b creq=%b addr=%h, required all zero", gnt_o, rvalid_o, cache_req_o, cache_addr_o);
    end
    crv = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid_o !== 2'b00) begin
      n_err++;
      $display("FAIL reset_rvalid: rvalid_o=%b, required 00", rvalid_o);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    a_addr[0] = 32'h0000_2000; a_we[0] = 1'b0; a_be[0] = 4'hF;
    drive(2'b01, 1'b1, 1'b0);
    n_cmp++;
    if ({gnt_o, cache_req_o, cache_addr_o} !== {2'b01, 1'b1, 32'h0000_2000}) begin
      n_err++;
      $display("FAIL single_grant: gnt=%b creq=%b addr=%h, required 01 1 00002000", gnt_o, cache_req_o, cache_addr_o);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b0); cyc();
    drive(2'b00, 1'b0, 1'b0); cyc();
    rdat = 32'hDEAD_BEEF;
    drive(2'b00, 1'b0, 1'b1);
    n_cmp++;
    if ({rvalid_o, rdata_o, err_o} !== {2'b01, 32'hDEAD_BEEF, 1'b0}) begin
      n_err++;
      $display("FAIL single_resp: rvalid=%b rdata=%h err=%b, required 01 deadbeef 0", rvalid_o, rdata_o, err_o);
    end
    cyc();
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, i > 0);
      want = (RR_MODE && (i % 2 == 1)) ? 2'b10 : 2'b01;
      n_cmp++;
      if (gnt_o !== want || rvalid_o !== e_rv) begin
        n_err++;
        $display("FAIL contention[%0d]: gnt=%b rv=%b, required %b %b", i, gnt_o, rvalid_o, want, e_rv);
      end
      cyc();
    end
    drive(2'b00, 1'b0, 1'b1); cyc();
  endtask

  task automatic test_interleaved();
    drive(2'b01, 1'b1, 1'b0); cyc();
    drive(2'b10, 1'b1, 1'b0);
    n_cmp++;
    if (gnt_o !== 2'b10) begin
      n_err++;
      $display("FAIL interleave_gnt1: gnt=%b, required 10", gnt_o);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    n_cmp++;
    if (rvalid_o !== 2'b01) begin
      n_err++;
      $display("FAIL interleave_rv0: rvalid=%b, required 01", rvalid_o);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    n_cmp++;
    if (rvalid_o !== 2'b10) begin
      n_err++;
      $display("FAIL interleave_rv1: rvalid=%b, required 10", rvalid_o);
    end
    cyc();
  endtask

  task automatic test_full();
    drive(2'b01, 1'b1, 1'b0); cyc();
    drive(2'b01, 1'b1, 1'b0); cyc();
    drive(2'b01, 1'b1, 1'b0);
    n_cmp++;
    if ({cache_req_o, gnt_o} !== 3'b0_00) begin
      n_err++;
      $display("FAIL full_block: creq=%b gnt=%b, required 0 00", cache_req_o, gnt_o);
    end
    cyc();
    drive(2'b01, 1'b1, 1'b1);
    n_cmp++;
    if ({cache_req_o, gnt_o, rvalid_o} !== 5'b0_00_01) begin
      n_err++;
      $display("FAIL full_rvalid: creq=%b gnt=%b rv=%b, required 0 00 01", cache_req_o, gnt_o, rvalid_o);
    end
    cyc();
    drive(2'b01, 1'b1, 1'b0);
    n_cmp++;
    if ({cache_req_o, gnt_o} !== 3'b1_01) begin
      n_err++;
      $display("FAIL full_resume: creq=%b gnt=%b, required 1 01", cache_req_o, gnt_o);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b1); cyc();
    drive(2'b00, 1'b0, 1'b1); cyc();
  endtask

  task automatic test_simultaneous();
    drive(2'b01, 1'b1, 1'b0); cyc();
    drive(2'b10, 1'b1, 1'b1);
    n_cmp++;
    if ({gnt_o, rvalid_o} !== 4'b10_01) begin
      n_err++;
      $display("FAIL simul_both: gnt=%b rv=%b, required 10 01", gnt_o, rvalid_o);
    end
    cyc();
    drive(2'b01, 1'b0, 1'b0);
    n_cmp++;
    if (cache_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL simul_count: creq=%b, required 1 (one outstanding)", cache_req_o);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    n_cmp++;
    if (rvalid_o !== 2'b10) begin
      n_err++;
      $display("FAIL simul_newid: rvalid=%b, required 10", rvalid_o);
    end
    cyc();
  endtask

  task automatic test_spurious();
    drive(2'b00, 1'b0, 1'b1);
    n_cmp++;
    if (rvalid_o !== 2'b00) begin
      n_err++;
      $display("FAIL spurious_drop: rvalid=%b, required 00", rvalid_o);
    end
    cyc();
    drive(2'b01, 1'b1, 1'b0); cyc();
    drive(2'b01, 1'b1, 1'b0); cyc();
    drive(2'b01, 1'b1, 1'b0);
    n_cmp++;
    if (cache_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_count: creq=%b after two grants, required 0", cache_req_o);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b1); cyc();
    drive(2'b00, 1'b0, 1'b1); cyc();
  endtask

  task automatic test_reset_mid();
    drive(2'b01, 1'b1, 1'b0); cyc();
    drive(2'b10, 1'b1, 1'b0); cyc();
    req = 2'b00; cgnt = 1'b0; crv = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid_o, cache_req_o, gnt_o} !== 5'b00_0_00) begin
      n_err++;
      $display("FAIL midreset_outs: rv=%b creq=%b gnt=%b, required 00 0 00", rvalid_o, cache_req_o, gnt_o);
    end
    q.delete();
    m_prio = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(2'b00, 1'b0, 1'b1);
    n_cmp++;
    if (rvalid_o !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_drop: rvalid=%b, required 00", rvalid_o);
    end
    cyc();
    drive(2'b11, 1'b1, 1'b0);
    n_cmp++;
    if (gnt_o !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_prio: gnt=%b, required 01", gnt_o);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b1); cyc();
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic       v;
    r = 2'b00;
    for (int c = 0; c < 500; c++) begin
      v = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      rdat = $urandom();
      cerr = $urandom_range(0, 1);
      drive(r, 1'($urandom_range(0, 3) != 0), v);
      n_cmp++;
      if ({gnt_o, rvalid_o, cache_req_o, cache_addr_o, cache_we_o, cache_be_o, cache_wdata_o, rdata_o, err_o} !==
          {e_gnt, e_rv, e_creq, e_addr, e_we, e_be, e_wd, rdat, cerr}) begin
        n_err++;
        $display("FAIL random[%0d]: gnt=%b rv=%b creq=%b addr=%h we=%b be=%h wd=%h rd=%h err=%b, required %b %b %b %h %b %h %h %h %b",
                 c, gnt_o, rvalid_o, cache_req_o, cache_addr_o, cache_we_o, cache_be_o, cache_wdata_o, rdata_o, err_o,
                 e_gnt, e_rv, e_creq, e_addr, e_we, e_be, e_wd, rdat, cerr);
      end
      // A requester keeps its request and payload until granted, then may start a fresh one.
      for (int n = 0; n < 2; n++) begin
        if (!(r[n] && !e_gnt[n])) begin
          r[n]      = 1'($urandom_range(0, 1));
          a_addr[n] = $urandom();
          a_we[n]   = 1'($urandom_range(0, 1));
          a_be[n]   = 4'($urandom_range(0, 15));
          a_wd[n]   = $urandom();
        end
      end
      cyc();
    end
    while (q.size() > 0) begin
      drive(2'b00, 1'b0, 1'b1); cyc();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_interleaved();
    test_full();
    test_simultaneous();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
